// File: rtl/dvsd_wtm_pipe.sv
// dvsd_wtm_pipe: pipelined Baugh-Wooley Wallace-tree multiplier with valid/ready on both sides.
// Define DVSD_WTM_ACC_EN to add the acc_clr port and an output-slice accumulator.
module dvsd_wtm_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               signed_mode,
`ifdef DVSD_WTM_ACC_EN
    input  logic               acc_clr,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] M
);
    localparam int P  = 2 * WIDTH;
    localparam int NR = WIDTH + 1;
`ifdef DVSD_WTM_ACC_EN
    localparam int TW = 2;
`else
    localparam int TW = 1;
`endif

    typedef logic [NR-1:0][P-1:0] rows_t;

    function automatic int rows_after(int k);
        int n = NR;
        for (int l = 0; l < k; l++) n = (n > 2) ? 2 * (n / 3) + n % 3 : n;
        return n;
    endfunction

    function automatic int num_levels();
        int l = 0;
        while (rows_after(l) > 2) l++;
        return l;
    endfunction

    localparam int L = num_levels();

    // Row WIDTH carries the Baugh-Wooley correction ones at columns WIDTH and 2*WIDTH-1.
    function automatic rows_t gen_pp(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic sm);
        rows_t x = '0;
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < WIDTH; j++)
                x[i][i+j] = (a[j] & b[i]) ^ (sm & ((i == WIDTH - 1) ^ (j == WIDTH - 1)));
        x[WIDTH][WIDTH] = sm;
        x[WIDTH][P-1]   = sm;
        return x;
    endfunction

    function automatic rows_t csa_level(rows_t x, int n);
        rows_t y = '0;
        for (int g = 0; g < NR / 3; g++)
            if (3 * g + 2 < n) begin
                y[2*g]   = x[3*g] ^ x[3*g+1] ^ x[3*g+2];
                y[2*g+1] = ((x[3*g] & x[3*g+1]) | (x[3*g] & x[3*g+2]) | (x[3*g+1] & x[3*g+2])) << 1;
            end
        for (int i = 0; i < NR; i++)
            if (i >= 3 * (n / 3) && i < n) y[2*(n/3)+i-3*(n/3)] = x[i];
        return y;
    endfunction

    function automatic rows_t reduce(rows_t x, int lo, int hi);
        rows_t y = x;
        for (int l = 0; l < NR; l++)
            if (l >= lo && l < hi) y = csa_level(y, rows_after(l));
        return y;
    endfunction

    // Rows beyond the surviving pair are zero, so summing every row is the final CPA.
    function automatic logic [P-1:0] cpa(rows_t x);
        logic [P-1:0] s = '0;
        for (int i = 0; i < NR; i++) s += x[i];
        return s;
    endfunction

    rows_t [STAGES-1:0] r, d, q;
    logic [STAGES-1:0][TW-1:0] t, dt;
    logic stall;
    logic [P-1:0] prod;

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = t[STAGES-1][0];

    for (genvar s = 0; s < STAGES; s++) begin : g_slice
        assign q[s] = reduce(r[s], L * s / STAGES, L * (s + 1) / STAGES);
        if (s == 0) begin : g_in
            assign d[0] = gen_pp(A, B, signed_mode);
`ifdef DVSD_WTM_ACC_EN
            assign dt[0] = {acc_clr, in_valid};
`else
            assign dt[0] = in_valid;
`endif
        end else begin : g_mid
            assign d[s]  = q[s-1];
            assign dt[s] = t[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r <= '0;
            t <= '0;
        end else if (!stall) begin
            r <= d;
            t <= dt;
        end

    assign prod = cpa(q[STAGES-1]);

`ifdef DVSD_WTM_ACC_EN
    logic [P-1:0] acc;

    assign M = (t[STAGES-1][TW-1] ? '0 : acc) + prod;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) acc <= '0;
        else if (out_valid && out_ready) acc <= M;
`else
    assign M = prod;
`endif
endmodule
